// File: rtl/cache_bus_arbiter.sv
// Arbitrates a single-ported RAM bus between instruction fetch and data memory, with data priority and bounded starvation.
// Optional statistics counters are compiled in when the ARB_STATS_EN macro is defined.
module cache_bus_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        bus_err
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_igrants,
    output logic [CNT_W-1:0] stat_dgrants,
    output logic [CNT_W-1:0] stat_aborts
`endif
);

    localparam int DS_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam int TC_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

    state_t          state, state_n;
    logic [DS_W-1:0] dstreak, dstreak_n;
    logic [TC_W-1:0] tcnt, tcnt_n;
    logic [31:0]     lat_addr, lat_store, cap_data;
    logic            lat_wr, lat_own_d;
    logic            bus_err_q;
    logic            grant_i, grant_d, abort, in_acc;

    assign in_acc = (state == IACC) || (state == DACC);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state;
        dstreak_n = dstreak;
        tcnt_n    = tcnt;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if ((dREN || dWEN) && !(iREN && dstreak == DS_W'(MAX_DSTREAK))) begin
                    grant_d = 1'b1;
                    state_n = DACC;
                    if (!iREN)
                        dstreak_n = '0;
                    else if (dstreak != DS_W'(MAX_DSTREAK))
                        dstreak_n = dstreak + DS_W'(1);
                end else if (iREN) begin
                    grant_i   = 1'b1;
                    state_n   = IACC;
                    dstreak_n = '0;
                end
            end
            IACC, DACC: begin
                if (ram_ready) begin
                    state_n = RESP;
                    tcnt_n  = '0;
                end else if (tcnt == TC_W'(TIMEOUT_CYC - 1)) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                    abort   = 1'b1;
                end else begin
                    tcnt_n = tcnt + TC_W'(1);
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            dstreak   <= '0;
            tcnt      <= '0;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_wr    <= 1'b0;
            lat_own_d <= 1'b0;
            cap_data  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            dstreak   <= dstreak_n;
            tcnt      <= tcnt_n;
            bus_err_q <= abort;
            if (grant_d) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_wr    <= dWEN;
                lat_own_d <= 1'b1;
            end else if (grant_i) begin
                lat_addr  <= iaddr;
                lat_store <= dstore;
                lat_wr    <= 1'b0;
                lat_own_d <= 1'b0;
            end
            if (in_acc && ram_ready)
                cap_data <= ramload;
        end
    end

    // Everything the bus sees is decoded from registered state, so outputs never glitch on request changes.
    assign ramREN   = in_acc && !lat_wr;
    assign ramWEN   = in_acc && lat_wr;
    assign ramaddr  = lat_addr;
    assign ramstore = lat_store;
    assign ihit     = (state == RESP) && !lat_own_d;
    assign dhit     = (state == RESP) && lat_own_d;
    assign iload    = cap_data;
    assign dload    = cap_data;
    assign bus_err  = bus_err_q;

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_igrants <= '0;
            stat_dgrants <= '0;
            stat_aborts  <= '0;
        end else begin
            if (grant_i) stat_igrants <= stat_igrants + CNT_W'(1);
            if (grant_d) stat_dgrants <= stat_dgrants + CNT_W'(1);
            if (abort)   stat_aborts  <= stat_aborts + CNT_W'(1);
        end
    end
`endif

endmodule
